// File: rtl/ball_position_pkg.sv
// ball_position_pkg: playfield geometry, rally FSM encoding and the X clamp shared by ball logic.
//  Shared with the bounce logic and renderer, so paddle rows live here too.
package ball_position_pkg;
   localparam int SCREEN_W    = 128;
   localparam int SCREEN_H    = 64;
   localparam int BALL_HALF   = 2;
   localparam int SERVE_TICKS = 30;
   localparam logic [6:0] SERVE_X    = 7'd64;
   localparam logic [5:0] SERVE_Y    = 6'd32;
   localparam logic [4:0] SERVE_LAST = 5'(SERVE_TICKS - 1);
   localparam logic [3:0] WIN_SCORE  = 4'd7;
   localparam logic [5:0] PADDLE_TOP_Y    = 6'd1;
   localparam logic [5:0] PADDLE_BOTTOM_Y = 6'd62;
   // Centre limits that keep the whole ball on screen, in the 9-bit signed step domain.
   localparam logic signed [8:0] X_MIN = 9'(BALL_HALF);
   localparam logic signed [8:0] X_MAX = 9'(SCREEN_W - 1 - BALL_HALF);
   localparam logic signed [8:0] Y_MIN = 9'(BALL_HALF);
   localparam logic signed [8:0] Y_MAX = 9'(SCREEN_H - 1 - BALL_HALF);
   typedef logic [1:0] state_t;
   localparam state_t ST_SERVE     = 2'd0;
   localparam state_t ST_PLAY      = 2'd1;
   localparam state_t ST_SCORED    = 2'd2;
   localparam state_t ST_GAME_OVER = 2'd3;
   function automatic logic [6:0] clamp_x(input logic signed [8:0] v);
      return (v < X_MIN) ? X_MIN[6:0] : (v > X_MAX) ? X_MAX[6:0] : v[6:0];
   endfunction
endpackage

// File: rtl/ball_position_if.sv
// ball_position_if: frame strobe, velocity and start in; position, pulses, scores and status out.
//  master: drives move_tick/start/dx/dy.  slave: the ball_position block.
interface ball_position_if;
   logic              move_tick;
   logic              start;
   logic signed [2:0] dx;
   logic signed [2:0] dy;
   logic [6:0]        ballX;
   logic [5:0]        ballY;
   logic              serve;
   logic              point_top;
   logic              point_bottom;
   logic [3:0]        score_top;
   logic [3:0]        score_bottom;
   logic              game_over;
   logic              in_play;
   modport master (
      output move_tick, start, dx, dy,
      input  ballX, ballY, serve, point_top, point_bottom, score_top, score_bottom, game_over, in_play
   );
   modport slave (
      input  move_tick, start, dx, dy,
      output ballX, ballY, serve, point_top, point_bottom, score_top, score_bottom, game_over, in_play
   );
endinterface

// File: rtl/ball_position.sv
// ball_position: integrates ball velocity per move_tick and sequences serve, scoring and game over.
//  clk  - system clock
//  rst  - asynchronous active-high reset
//  bus  - slave side: move_tick/start/dx/dy in; ballX/ballY, serve/point pulses, scores,
//         game_over and in_play out
module ball_position
   import ball_position_pkg::*;
(
   input logic            clk,
   input logic            rst,
   ball_position_if.slave bus
);
   state_t            state;
   logic [4:0]        tick_cnt;
   logic [6:0]        ball_x;
   logic [5:0]        ball_y;
   logic [3:0]        score_top, score_bottom;
   logic              serve, point_top, point_bottom;
   logic signed [8:0] nx, ny;
   always_comb begin
      nx = $signed({2'b00, ball_x}) + $signed({{6{bus.dx[2]}}, bus.dx});
      ny = $signed({3'b000, ball_y}) + $signed({{6{bus.dy[2]}}, bus.dy});
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_SERVE;
         tick_cnt     <= '0;
         ball_x       <= SERVE_X;
         ball_y       <= SERVE_Y;
         score_top    <= '0;
         score_bottom <= '0;
         serve        <= 1'b0;
         point_top    <= 1'b0;
         point_bottom <= 1'b0;
      end else begin
         serve        <= 1'b0;
         point_top    <= 1'b0;
         point_bottom <= 1'b0;
         case (state)
            ST_SERVE: begin
               ball_x <= SERVE_X;
               ball_y <= SERVE_Y;
               if (bus.move_tick) begin
                  tick_cnt <= (tick_cnt == SERVE_LAST) ? 5'd0 : tick_cnt + 5'd1;
                  if (tick_cnt == SERVE_LAST) begin
                     state <= ST_PLAY;
                     serve <= 1'b1;
                  end
               end
            end
            ST_PLAY: begin
               // Scoring ticks leave the last in-field position in place.
               if (bus.move_tick) begin
                  if (ny < Y_MIN) begin
                     point_bottom <= 1'b1;
                     if (score_bottom != WIN_SCORE) score_bottom <= score_bottom + 4'd1;
                     state <= ST_SCORED;
                  end else if (ny > Y_MAX) begin
                     point_top <= 1'b1;
                     if (score_top != WIN_SCORE) score_top <= score_top + 4'd1;
                     state <= ST_SCORED;
                  end else begin
                     ball_y <= ny[5:0];
                     ball_x <= clamp_x(nx);
                  end
               end
            end
            ST_SCORED: begin
               ball_x <= SERVE_X;
               ball_y <= SERVE_Y;
               state  <= (score_top == WIN_SCORE || score_bottom == WIN_SCORE) ? ST_GAME_OVER : ST_SERVE;
            end
            default: begin
               if (bus.start) begin
                  score_top    <= '0;
                  score_bottom <= '0;
                  tick_cnt     <= '0;
                  state        <= ST_SERVE;
               end
            end
         endcase
      end
   end
   assign bus.ballX        = ball_x;
   assign bus.ballY        = ball_y;
   assign bus.serve        = serve;
   assign bus.point_top    = point_top;
   assign bus.point_bottom = point_bottom;
   assign bus.score_top    = score_top;
   assign bus.score_bottom = score_bottom;
   assign bus.game_over    = (state == ST_GAME_OVER);
   assign bus.in_play      = (state == ST_PLAY);
endmodule

// File: tb/tb_ball_position.sv
// tb_ball_position: directed rally table, reset/start sequences and a randomized run against a rule-level model.
module tb_ball_position;
   logic clk = 1'b0;
   logic rst = 1'b1;
   ball_position_if bus ();
   ball_position dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string name;
      int    dx, dy, n;
      int    ex, ey, est, esb;
      bit    eplay, ego;
      int    eserve, ept, epb;
   } row_t;
   row_t rows[$];

   int n_serve, n_pt, n_pb;

   // Rule-level model: phase 0 serve, 1 play, 2 scored, 3 game over.
   int m_phase, m_cnt, m_x, m_y, m_st, m_sb;
   bit m_serve, m_pt, m_pb;

   function automatic void add(string name, int dx, int dy, int n, int ex, int ey, int est, int esb,
                               bit eplay, bit ego, int eserve, int ept, int epb);
      row_t r;
      r.name = name; r.dx = dx; r.dy = dy; r.n = n; r.ex = ex; r.ey = ey; r.est = est; r.esb = esb;
      r.eplay = eplay; r.ego = ego; r.eserve = eserve; r.ept = ept; r.epb = epb;
      rows.push_back(r);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input bit mt);
      bus.move_tick = mt;
      @(posedge clk);
      #1;
      n_serve += int'(bus.serve);
      n_pt    += int'(bus.point_top);
      n_pb    += int'(bus.point_bottom);
   endtask

   function automatic logic [31:0] dut_vec();
      return {6'd0, bus.ballX, bus.ballY, bus.serve, bus.point_top, bus.point_bottom,
              bus.score_top, bus.score_bottom, bus.game_over, bus.in_play};
   endfunction

   function automatic logic [31:0] model_vec();
      return {6'd0, 7'(m_x), 6'(m_y), m_serve, m_pt, m_pb, 4'(m_st), 4'(m_sb),
              m_phase == 3, m_phase == 1};
   endfunction

   function automatic void model_reset();
      m_phase = 0; m_cnt = 0; m_x = 64; m_y = 32; m_st = 0; m_sb = 0;
      m_serve = 0; m_pt = 0; m_pb = 0;
   endfunction

   function automatic void model_step(bit mt, bit st, int vx, int vy);
      int x, y;
      m_serve = 0; m_pt = 0; m_pb = 0;
      case (m_phase)
         0: if (mt) begin
               m_cnt++;
               if (m_cnt == 30) begin m_phase = 1; m_cnt = 0; m_serve = 1; end
            end
         1: if (mt) begin
               x = m_x + vx;
               y = m_y + vy;
               if (y - 2 < 0) begin
                  m_pb = 1; if (m_sb < 7) m_sb++; m_phase = 2;
               end else if (y + 2 > 63) begin
                  m_pt = 1; if (m_st < 7) m_st++; m_phase = 2;
               end else begin
                  m_y = y;
                  m_x = (x < 2) ? 2 : (x > 125) ? 125 : x;
               end
            end
         2: begin
               m_x = 64; m_y = 32;
               m_phase = (m_st == 7 || m_sb == 7) ? 3 : 0;
            end
         default: if (st) begin m_st = 0; m_sb = 0; m_cnt = 0; m_phase = 0; end
      endcase
   endfunction

   initial begin
      int vx, vy;
      bus.move_tick = 1'b0;
      bus.start     = 1'b0;
      bus.dx        = '0;
      bus.dy        = '0;

      add("serve1",    0,  0, 30,  64, 32, 0, 0, 1, 0, 1, 0, 0);
      add("step",      1, -1,  1,  65, 31, 0, 0, 1, 0, 0, 0, 0);
      add("climb",     0, -1, 29,  65,  2, 0, 0, 1, 0, 0, 0, 0);
      add("exit_top",  0, -1,  1,  64, 32, 0, 1, 0, 0, 0, 0, 1);
      add("serve2",    0,  0, 30,  64, 32, 0, 1, 1, 0, 1, 0, 0);
      add("right",     2,  0, 30, 124, 32, 0, 1, 1, 0, 0, 0, 0);
      add("clamp_r",   2,  0,  1, 125, 32, 0, 1, 1, 0, 0, 0, 0);
      add("left",     -2,  0, 61,   3, 32, 0, 1, 1, 0, 0, 0, 0);
      add("clamp_l",  -2,  0,  1,   2, 32, 0, 1, 1, 0, 0, 0, 0);
      add("exit_bot",  0,  2, 15,  64, 32, 1, 1, 0, 0, 0, 1, 0);
      for (int k = 2; k <= 6; k++) begin
         add("serve_k",  0, 0, 30, 64, 32, k - 1, 1, 1, 0, 1, 0, 0);
         add("exit_k",   0, 2, 15, 64, 32, k,     1, 0, 0, 0, 1, 0);
      end
      add("serve7",    0,  0, 30,  64, 32, 6, 1, 1, 0, 1, 0, 0);
      add("down",      0,  1, 29,  64, 61, 6, 1, 1, 0, 0, 0, 0);
      add("win",       0,  1,  1,  64, 32, 7, 1, 0, 1, 0, 1, 0);
      add("idle",      1,  1,  5,  64, 32, 7, 1, 0, 1, 0, 0, 0);

      repeat (2) @(posedge clk);
      #1;
      check("reset", dut_vec(), {6'd0, 7'd64, 6'd32, 3'b000, 8'h00, 2'b00});
      rst = 1'b0;

      foreach (rows[i]) begin
         bus.dx = 3'(rows[i].dx);
         bus.dy = 3'(rows[i].dy);
         n_serve = 0; n_pt = 0; n_pb = 0;
         for (int t = 0; t < rows[i].n; t++) begin
            cyc(1'b1);
            cyc(1'b0);
         end
         check({rows[i].name, " pos"}, {19'd0, bus.ballX, bus.ballY}, {19'd0, 7'(rows[i].ex), 6'(rows[i].ey)});
         check({rows[i].name, " score"}, {24'd0, bus.score_top, bus.score_bottom},
               {24'd0, 4'(rows[i].est), 4'(rows[i].esb)});
         check({rows[i].name, " state"}, {30'd0, bus.in_play, bus.game_over},
               {30'd0, rows[i].eplay, rows[i].ego});
         check({rows[i].name, " pulses"}, {8'd0, 8'(n_serve), 8'(n_pt), 8'(n_pb)},
               {8'd0, 8'(rows[i].eserve), 8'(rows[i].ept), 8'(rows[i].epb)});
      end

      bus.start = 1'b1;
      cyc(1'b0);
      bus.start = 1'b0;
      check("start scores", {24'd0, bus.score_top, bus.score_bottom}, 32'd0);
      check("start state", {30'd0, bus.in_play, bus.game_over}, 32'd0);

      bus.dx = 3'sd1;
      bus.dy = 3'sd2;
      for (int t = 0; t < 35; t++) begin
         cyc(1'b1);
         cyc(1'b0);
      end
      check("pre_rst pos", {19'd0, bus.ballX, bus.ballY}, {19'd0, 7'd69, 6'd42});
      #3 rst = 1'b1;
      #1;
      check("async rst pos", {19'd0, bus.ballX, bus.ballY}, {19'd0, 7'd64, 6'd32});
      check("async rst play", {31'd0, bus.in_play}, 32'd0);
      n_serve = 0; n_pt = 0; n_pb = 0;
      cyc(1'b1);
      check("rst no pulse", {8'd0, 8'(n_serve), 8'(n_pt), 8'(n_pb)}, 32'd0);
      bus.move_tick = 1'b0;
      rst = 1'b0;

      model_reset();
      vx = 0; vy = 0;
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(39) == 0) begin
            vx = int'($urandom_range(4)) - 2;
            vy = int'($urandom_range(4)) - 2;
         end
         bus.move_tick = 1'($urandom_range(1));
         bus.start     = ($urandom_range(63) == 0);
         bus.dx        = 3'(vx);
         bus.dy        = 3'(vy);
         model_step(bus.move_tick, bus.start, vx, vy);
         @(posedge clk);
         #1;
         check("random", dut_vec(), model_vec());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
